// File: rtl/ram_limb_streamer_if.sv
// Limb stream channel from the RAM read sequencer to the modular-multiplier datapath.
// Handshake: a beat transfers on a rising clk edge where m_valid and m_ready are both
// high; once m_valid rises, m_data and m_last hold until that transfer, and m_valid
// never depends combinationally on m_ready.
interface ram_limb_streamer_if #(
  parameter int RAM_WIDTH = 16
);
  logic                 m_valid;
  logic [RAM_WIDTH-1:0] m_data;
  logic                 m_last;
  logic                 m_ready;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/ram_limb_streamer.sv
// Read-side sequencer for the limb RAM: issues sequential reads over a limb range,
// absorbs the one-cycle RAM latency and streams limbs LSB-first through a 2-entry FIFO.
module ram_limb_streamer #(
  parameter int RAM_WIDTH = 16,
  parameter int ADDR_LINE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_LINE-1:0] base_addr,
  input  logic [ADDR_LINE:0]   num_limbs,
  output logic                 busy,
  output logic                 done,
  output logic                 ram_rd_en,
  output logic [ADDR_LINE-1:0] ram_rd_addr,
  input  logic [RAM_WIDTH-1:0] ram_rd_data,
  ram_limb_streamer_if.master  m,
  output logic [1:0]           dbg_state
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [ADDR_LINE:0] ONE = 1;

  state_t               state;
  logic [ADDR_LINE-1:0] base_q;
  logic [ADDR_LINE:0]   num_q;
  logic [ADDR_LINE:0]   issued;
  logic [ADDR_LINE:0]   delivered;
  logic                 inflight;
  logic [RAM_WIDTH-1:0] fifo_mem [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           count;
  logic [1:0]           occupancy;
  logic                 hs;
  logic                 last_hs;
  logic                 issue;

  // Buffered limbs plus the read still travelling through the RAM; never exceeds 2.
  assign occupancy = count + {1'b0, inflight};

  assign m.m_valid = (count != 2'd0);
  assign m.m_data  = m.m_valid ? fifo_mem[rd_ptr] : '0;
  // Head limb index equals the number of limbs already handed downstream.
  assign m.m_last  = m.m_valid && (delivered == (num_q - ONE));

  assign hs      = m.m_valid && m.m_ready;
  assign last_hs = hs && m.m_last;

  // A read may take the last free slot only when a pop frees one on the same edge.
  assign issue = (state == RUN) && (issued < num_q) &&
                 ((occupancy < 2'd2) || ((occupancy == 2'd2) && hs));

  assign ram_rd_en   = issue;
  assign ram_rd_addr = issue ? (base_q + issued[ADDR_LINE-1:0]) : '0;
  assign dbg_state   = state;

  // Command FSM with registered busy/done, plus read and delivery counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      base_q    <= '0;
      num_q     <= '0;
      issued    <= '0;
      delivered <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) issued <= issued + ONE;
      if (hs) delivered <= delivered + ONE;
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            base_q    <= base_addr;
            num_q     <= num_limbs;
            issued    <= '0;
            delivered <= '0;
            busy      <= 1'b1;
            if (num_limbs == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (last_hs) begin
            state <= FIN;
            done  <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Two-entry output FIFO: RAM data lands one cycle after its read, head pops on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
    end else begin
      if (inflight) begin
        fifo_mem[wr_ptr] <= ram_rd_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (hs) rd_ptr <= ~rd_ptr;
      case ({inflight, hs})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end
endmodule
